// File: rtl/deint_pkg.sv
// Shared constants and FSM state type for the block deinterleaver sequencer.
package deint_pkg;

  localparam int unsigned BRANCHES_DEF = 12;
  localparam int unsigned ROWS_DEF     = 8;
  localparam int unsigned BRANCH_W     = 4;
  localparam int unsigned FRAME_CNT_W  = 16;

  localparam logic [BRANCH_W-1:0] BRANCH_FIRST = 4'd1;
  localparam logic [BRANCH_W-1:0] SEL_NONE     = 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/deint_branch_counter.sv
// Branch counter cycling 1..BRANCHES; wrap pulses on the advance out of the last branch.
module deint_branch_counter
  import deint_pkg::*;
#(
  parameter int unsigned BRANCHES = BRANCHES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [BRANCH_W-1:0] value,
  output logic                wrap
);

  logic [BRANCH_W-1:0] r_value;
  logic                w_at_last;

  assign w_at_last = (r_value == BRANCH_W'(BRANCHES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= BRANCH_FIRST;
    end else if (en) begin
      r_value <= w_at_last ? BRANCH_FIRST : r_value + BRANCH_W'(1);
    end
  end

  assign value = r_value;
  assign wrap  = en & w_at_last;

endmodule

// File: rtl/deinterleaver_sequencer.sv
// Row-wise write / column-major read sequencer for a block deinterleaver RAM.
// Optional DEINT_FRAME_CNT_EN adds a saturating 16-bit completed-frame counter.
module deinterleaver_sequencer
  import deint_pkg::*;
#(
  parameter  int unsigned BRANCHES = BRANCHES_DEF,
  parameter  int unsigned ROWS     = ROWS_DEF,
  localparam int unsigned ROW_W    = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BRANCH_W-1:0]    wr_sel,
  output logic [ROW_W-1:0]       wr_row,
  output logic                   rd_en,
  output logic [BRANCH_W-1:0]    rd_branch,
  output logic [ROW_W-1:0]       rd_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_done,
`ifdef DEINT_FRAME_CNT_EN
  output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
  output logic                   busy
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_accept;
  logic                w_wr_wrap;
  logic                w_wr_row_last;
  logic                w_fill_done;
  logic                w_rd_row_last;
  logic                w_rd_branch_adv;
  logic                w_last_read;
  logic [BRANCH_W-1:0] w_wr_branch;
  logic [ROW_W-1:0]    r_wr_row;
  logic [ROW_W-1:0]    r_rd_row;
  logic                r_out_valid;

  assign in_ready        = (r_state != DRAIN);
  assign busy            = (r_state != IDLE);
  assign w_accept        = in_valid & in_ready;
  assign wr_sel          = w_accept ? w_wr_branch : SEL_NONE;
  assign rd_en           = (r_state == DRAIN) & (~r_out_valid | out_ready);
  assign w_wr_row_last   = (r_wr_row == ROW_W'(ROWS - 1));
  assign w_rd_row_last   = (r_rd_row == ROW_W'(ROWS - 1));
  assign w_fill_done     = w_wr_wrap & w_wr_row_last;
  assign w_rd_branch_adv = rd_en & w_rd_row_last;
  assign frame_done      = w_last_read;
  assign wr_row          = r_wr_row;
  assign rd_row          = r_rd_row;
  assign out_valid       = r_out_valid;

  deint_branch_counter #(.BRANCHES(BRANCHES)) u_wr_branch (
    .clk   (clk),
    .rst   (rst),
    .en    (w_accept),
    .value (w_wr_branch),
    .wrap  (w_wr_wrap)
  );

  // Read branch wraps exactly on the final read of the frame.
  deint_branch_counter #(.BRANCHES(BRANCHES)) u_rd_branch (
    .clk   (clk),
    .rst   (rst),
    .en    (w_rd_branch_adv),
    .value (rd_branch),
    .wrap  (w_last_read)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = FILL;
      FILL:    if (w_fill_done) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_read) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_row <= '0;
    end else if (w_wr_wrap) begin
      r_wr_row <= w_wr_row_last ? '0 : r_wr_row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_row <= '0;
    end else if (rd_en) begin
      r_rd_row <= w_rd_row_last ? '0 : r_rd_row + ROW_W'(1);
    end
  end

  // Data follows the RAM read by one cycle and holds until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= rd_en | (r_out_valid & ~out_ready);
    end
  end

`ifdef DEINT_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_last_read && (r_frame_cnt != '1)) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
